// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//
// Shared definitions for the countdown timer and the display logic that reads
// its outputs.
//
// Contents:
//   state_t            - controller state encoding (IDLE, RUN, PAUSE, ALARM)
//   TIMER_WIDTH        - default width of the duration / remaining fields
//   TIMER_ALARM_TICKS  - default number of ticks the alarm is held
//   is_busy_state()    - true for the states where a countdown is in progress
// -----------------------------------------------------------------------------
package timer_pkg;

    // Controller states. The encoding is fixed so downstream debug logic can
    // decode a captured state value without a lookup table.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    // Default field width for durations and remaining seconds.
    localparam int TIMER_WIDTH = 8;

    // Default alarm hold time in ticks (legal range 1..255).
    localparam int TIMER_ALARM_TICKS = 5;

    // A countdown is "in progress" while running or paused.
    function automatic logic is_busy_state(input state_t s);
        return (s == RUN) || (s == PAUSE);
    endfunction

endpackage

// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
//
// Countdown timer controller. Accepts a duration (seconds) over a valid/ready
// handshake while idle, counts it down on the 1 Hz tick strobe, supports a
// level-sensitive pause, and on expiry raises a timed alarm before returning
// to idle. `clear` aborts to idle from any state.
//
// Parameters:
//   WIDTH        - width of load_val / remaining
//   ALARM_TICKS  - ticks the alarm stays high before auto-return (1..255)
//
// Ports:
//   clk          in   system clock
//   nrst         in   synchronous active-low reset
//   tick         in   1 Hz strobe, one cycle high per second
//   load_valid   in   load_val is valid
//   load_ready   out  controller accepts a load (idle only)
//   load_val     in   duration in seconds
//   pause        in   level; freezes the countdown while high
//   clear        in   abort to idle
//   ack          in   silences the alarm early
//   remaining    out  seconds left
//   busy         out  running or paused
//   done         out  one-cycle pulse on expiry
//   alarm        out  high throughout the alarm phase
//
// All outputs come straight from flops. The output flops are loaded from the
// *next* state so that they change on the same edge as the state register.
// -----------------------------------------------------------------------------
module countdown_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH       = TIMER_WIDTH,
    parameter int ALARM_TICKS = TIMER_ALARM_TICKS
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             tick,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             clear,
    input  logic             ack,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             alarm
);

    // Constants with explicit widths so comparisons and arithmetic never
    // rely on implicit extension.
    localparam logic [WIDTH-1:0] ZERO_SECS  = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE_SEC    = WIDTH'(1);
    localparam logic [7:0]       ALARM_ZERO = 8'd0;
    localparam logic [7:0]       ALARM_ONE  = 8'd1;
    // Counter value at which the next tick ends the alarm phase.
    localparam logic [7:0]       ALARM_LAST = 8'(ALARM_TICKS - 1);

    // Registered state and datapath.
    state_t            state_r;
    logic [WIDTH-1:0]  remaining_r;
    logic [7:0]        alarm_cnt_r;
    logic              done_r;
    logic              alarm_r;
    logic              busy_r;
    logic              load_ready_r;

    // Next-state values.
    state_t            state_s;
    logic [WIDTH-1:0]  remaining_s;
    logic [7:0]        alarm_cnt_s;
    logic              done_s;

    // Next-state, next-remaining and expiry-pulse decode.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        alarm_cnt_s = alarm_cnt_r;
        done_s      = 1'b0;

        if (clear) begin
            // Abort wins over everything except reset, including a
            // simultaneous load request in IDLE.
            state_s     = IDLE;
            remaining_s = ZERO_SECS;
            alarm_cnt_s = ALARM_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load_valid) begin
                        remaining_s = load_val;
                        if (load_val == ZERO_SECS) begin
                            // Zero duration expires immediately.
                            state_s     = ALARM;
                            alarm_cnt_s = ALARM_ZERO;
                            done_s      = 1'b1;
                        end else begin
                            state_s = RUN;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end

                RUN: begin
                    if (pause) begin
                        // A tick in the same cycle as entering pause is lost.
                        state_s = PAUSE;
                    end else if (tick) begin
                        // Expire on 1 -> 0. The "<=" also covers an
                        // unreachable zero so the count can never wrap.
                        if (remaining_r <= ONE_SEC) begin
                            remaining_s = ZERO_SECS;
                            state_s     = ALARM;
                            alarm_cnt_s = ALARM_ZERO;
                            done_s      = 1'b1;
                        end else begin
                            remaining_s = remaining_r - ONE_SEC;
                        end
                    end else begin
                        state_s = RUN;
                    end
                end

                PAUSE: begin
                    // Ticks are ignored here, including one coinciding with
                    // the release of pause.
                    if (!pause) begin
                        state_s = RUN;
                    end else begin
                        state_s = PAUSE;
                    end
                end

                ALARM: begin
                    remaining_s = ZERO_SECS;
                    if (ack) begin
                        // Early silence; a concurrent tick is not counted.
                        state_s     = IDLE;
                        alarm_cnt_s = ALARM_ZERO;
                    end else if (tick) begin
                        if (alarm_cnt_r >= ALARM_LAST) begin
                            state_s     = IDLE;
                            alarm_cnt_s = ALARM_ZERO;
                        end else begin
                            alarm_cnt_s = alarm_cnt_r + ALARM_ONE;
                        end
                    end else begin
                        state_s = ALARM;
                    end
                end

                default: begin
                    // Unreachable with a 4-state enum; recover to a safe idle.
                    state_s     = IDLE;
                    remaining_s = ZERO_SECS;
                    alarm_cnt_s = ALARM_ZERO;
                end
            endcase
        end
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r      <= IDLE;
            remaining_r  <= ZERO_SECS;
            alarm_cnt_r  <= ALARM_ZERO;
            done_r       <= 1'b0;
            alarm_r      <= 1'b0;
            busy_r       <= 1'b0;
            load_ready_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            remaining_r  <= remaining_s;
            alarm_cnt_r  <= alarm_cnt_s;
            done_r       <= done_s;
            alarm_r      <= (state_s == ALARM);
            busy_r       <= is_busy_state(state_s);
            load_ready_r <= (state_s == IDLE);
        end
    end

    assign remaining  = remaining_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign alarm      = alarm_r;
    assign load_ready = load_ready_r;

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
//
// Self-checking bench for countdown_ctrl (WIDTH=8, ALARM_TICKS=5). A table of
// directed vectors with hand-computed expectations, two hand-written
// multi-cycle sequences, then randomized traffic. Every cycle is also checked
// against a behavioural model that tracks "seconds left", "counting",
// "paused" and "alarm ticks seen" directly.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;

    localparam int W  = 8;
    localparam int AT = 5;

    logic         clk;
    logic         nrst;
    logic         tick;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_val;
    logic         pause;
    logic         clear;
    logic         ack;
    logic [W-1:0] remaining;
    logic         busy;
    logic         done;
    logic         alarm;

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    countdown_ctrl #(.WIDTH(W), .ALARM_TICKS(AT)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .tick       (tick),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_val   (load_val),
        .pause      (pause),
        .clear      (clear),
        .ack        (ack),
        .remaining  (remaining),
        .busy       (busy),
        .done       (done),
        .alarm      (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int  m_secs;        // seconds left
    bit  m_counting;    // a countdown is in progress (running or paused)
    bit  m_paused;
    bit  m_alarming;
    int  m_alarm_seen;  // ticks counted since the alarm started
    bit  m_done;

    task automatic model_step(input logic n, c, t, p, a, lv, input logic [W-1:0] v);
        m_done = 1'b0;
        if (!n || c) begin
            m_secs = 0; m_counting = 0; m_paused = 0; m_alarming = 0; m_alarm_seen = 0;
        end else if (m_alarming) begin
            m_secs = 0;
            if (a) m_alarming = 0;
            else if (t) begin
                m_alarm_seen++;
                if (m_alarm_seen >= AT) m_alarming = 0;
            end
        end else if (m_counting) begin
            if (m_paused) begin
                if (!p) m_paused = 0;
            end else if (p) begin
                m_paused = 1;
            end else if (t) begin
                if (m_secs == 1) begin
                    m_secs = 0; m_counting = 0; m_alarming = 1; m_alarm_seen = 0; m_done = 1;
                end else begin
                    m_secs = m_secs - 1;
                end
            end
        end else if (lv) begin
            m_secs = int'(v);
            if (v == 0) begin
                m_alarming = 1; m_alarm_seen = 0; m_done = 1;
            end else begin
                m_counting = 1; m_paused = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s actual=%0d expected=%0d t=%0t", phase, name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("m.remaining",  32'(remaining),  32'(m_secs));
        check("m.busy",       32'(busy),       32'(m_counting));
        check("m.done",       32'(done),       32'(m_done));
        check("m.alarm",      32'(alarm),      32'(m_alarming));
        check("m.load_ready", 32'(load_ready), 32'(!m_counting && !m_alarming));
    endtask

    // Drive one cycle of inputs, advance past the edge, compare with model.
    task automatic cyc(input logic n, c, t, p, a, lv, input logic [W-1:0] v);
        nrst = n; clear = c; tick = t; pause = p; ack = a; load_valid = lv; load_val = v;
        @(posedge clk);
        model_step(n, c, t, p, a, lv, v);
        #1;
        check_model();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         n, c, t, p, a, lv;
        logic [W-1:0] v;
        logic [W-1:0] e_rem;
        logic         e_busy, e_done, e_alarm, e_ready;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic n, c, t, p, a, lv, input logic [W-1:0] v,
                                input logic [W-1:0] er, input logic eb, ed, ea, ey);
        vec_t r;
        r.n = n; r.c = c; r.t = t; r.p = p; r.a = a; r.lv = lv; r.v = v;
        r.e_rem = er; r.e_busy = eb; r.e_done = ed; r.e_alarm = ea; r.e_ready = ey;
        return r;
    endfunction

    initial begin
        nrst = 1'b0; clear = 1'b0; tick = 1'b0; pause = 1'b0; ack = 1'b0;
        load_valid = 1'b0; load_val = 8'd0;
        m_secs = 0; m_counting = 0; m_paused = 0; m_alarming = 0; m_alarm_seen = 0; m_done = 0;

        //                n     c     t     p     a     lv    val    | rem   busy  done  alarm ready
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b0, 1'b1)); // reset
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3,   8'd3, 1'b1, 1'b0, 1'b0, 1'b0)); // load 3
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b1, 1'b1, 1'b0)); // expiry
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0)); // done gone
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0)); // alarm tick 1
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0)); // 2
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0)); // 3
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0)); // 4
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b0, 1'b1)); // 5 -> idle
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   8'd0, 1'b0, 1'b1, 1'b1, 1'b0)); // load 0
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0)); // 1st tick
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b0, 1'b1)); // ack+tick
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1,   8'd0, 1'b0, 1'b0, 1'b0, 1'b1)); // clear+load
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1,   8'd1, 1'b1, 1'b0, 1'b0, 1'b0)); // load 1
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   8'd1, 1'b1, 1'b0, 1'b0, 1'b0)); // pause+tick
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd1, 1'b1, 1'b0, 1'b0, 1'b0)); // release+tick
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b1, 1'b1, 1'b0)); // expiry
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b0, 1'b1)); // nrst in alarm
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2,   8'd2, 1'b1, 1'b0, 1'b0, 1'b0)); // load 2
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd9,   8'd1, 1'b1, 1'b0, 1'b0, 1'b0)); // load ignored
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b1, 1'b1, 1'b0)); // expiry
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b0, 1'b1)); // clear in alarm

        phase = "table";
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].n, tbl[i].c, tbl[i].t, tbl[i].p, tbl[i].a, tbl[i].lv, tbl[i].v);
            check($sformatf("v%0d.remaining", i),  32'(remaining),  32'(tbl[i].e_rem));
            check($sformatf("v%0d.busy", i),       32'(busy),       32'(tbl[i].e_busy));
            check($sformatf("v%0d.done", i),       32'(done),       32'(tbl[i].e_done));
            check($sformatf("v%0d.alarm", i),      32'(alarm),      32'(tbl[i].e_alarm));
            check($sformatf("v%0d.load_ready", i), 32'(load_ready), 32'(tbl[i].e_ready));
        end

        // Load 10, 4 ticks, pause across 3 ticks, release, 6 ticks to expiry.
        phase = "pause10";
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check("rem_before_pause", 32'(remaining), 32'd6);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
            check("rem_paused", 32'(remaining), 32'd6);
            check("busy_paused", 32'(busy), 32'd1);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check("rem_after_5", 32'(remaining), 32'd1);
        check("no_done_early", 32'(done), 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check("done_6th", 32'(done), 32'd1);
        check("alarm_6th", 32'(alarm), 32'd1);
        check("busy_6th", 32'(busy), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        check("ack_idle", 32'(load_ready), 32'd1);

        // Load 200, 50 ticks with stray load requests, then clear.
        phase = "clear200";
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd200);
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'(i + 3));
        check("rem_150", 32'(remaining), 32'd150);
        check("ready_run", 32'(load_ready), 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7);
        check("clr_rem", 32'(remaining), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_ready", 32'(load_ready), 32'd1);

        // Randomized traffic against the model.
        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            logic         rn, rc, rt, rp, ra, rl;
            logic [W-1:0] rv;
            rn = ($urandom_range(0, 299) != 0);
            rc = ($urandom_range(0, 99) == 0);
            rt = ($urandom_range(0, 2) == 0);
            rp = ($urandom_range(0, 5) == 0);
            ra = ($urandom_range(0, 11) == 0);
            rl = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            cyc(rn, rc, rt, rp, ra, rl, rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Countdown timer controller driven by the design's 1 Hz tick strobe (one-cycle `secpulse` from the top-level divider). It accepts a duration in seconds over a valid/ready load handshake and sequences run, pause and expiry. On expiry it raises a timed alarm, then returns to idle. It sits between the user-input logic and the display/alarm outputs, and is the only consumer that interprets the tick as a time base.

## Interface
- `WIDTH`, 8: width of the duration and remaining-seconds fields.
- `ALARM_TICKS`, 5: number of ticks the alarm stays asserted before auto-return to idle; legal range 1..255.
- `clk` in 1: system clock.
- `nrst` in 1: reset; synchronous, active-low, sampled on the rising edge of `clk`.
- `tick` in 1: 1 Hz strobe; each cycle it is high counts as one second.
- `load_valid` in 1: `load_val` is valid.
- `load_ready` out 1: controller can accept a load; high only in IDLE.
- `load_val` in WIDTH: duration in seconds.
- `pause` in 1: level; freezes countdown while high.
- `clear` in 1: abort to IDLE.
- `ack` in 1: silences the alarm early.
- `remaining` out WIDTH: seconds left.
- `busy` out 1: state is RUN or PAUSE.
- `done` out 1: one-cycle pulse on expiry.
- `alarm` out 1: high throughout the ALARM state.

## Operation
- States (package enum): IDLE, RUN, PAUSE, ALARM. Reset and `clear` both enter IDLE.
- Priority per edge, highest first: `nrst`=0, then `clear`, then state logic.
- IDLE
  - `load_ready`=1.
  - On `load_valid`: `remaining`<=`load_val`.
  - Next state is RUN if `load_val`≠0.
  - Next state is ALARM if `load_val`=0; `done` pulses in that case.
- RUN
  - `pause`=1 → PAUSE. A tick in the same cycle is dropped.
  - Else on `tick`:
    - `remaining`=1 → `remaining`<=0, ALARM, `done`<=1.
    - Otherwise `remaining`<=`remaining`-1.
- PAUSE
  - Ticks are ignored.
  - `pause`=0 → RUN. A tick arriving in that same cycle is still ignored.
- ALARM
  - Internal 8-bit counter, zeroed on entry, increments on each `tick`.
  - Exit to IDLE in either case:
    - a tick arrives when the counter is `ALARM_TICKS`-1;
    - `ack`=1, which takes priority over the tick.
  - `remaining` stays 0.
- Arithmetic
  - `remaining` never wraps. The decrement only occurs when `remaining`≥2 or on the 1→0 expiry.
- Loads outside IDLE
  - `load_valid` is ignored (`load_ready`=0). No buffering; the requester must hold the request until it is accepted.

## Timing
- All outputs are registered.
- Reset values: `remaining`=0, `busy`=0, `done`=0, `alarm`=0, `load_ready`=1, state IDLE.
- Load accepted at edge N:
  - `busy`=1 and `remaining`=`load_val` from N.
  - `load_ready`=0 from N.
- Expiry: tick sampled at edge N with `remaining`=1:
  - `done`=1 for the cycle after N only.
  - `alarm`=1 from N until the exit edge.
  - `busy`=0 from N.
- Total run time: `load_val` ticks, excluding ticks that arrive while paused.
- `clear` at edge N: all outputs at reset values after N, regardless of state. Same for `nrst`=0 mid-operation.
- `ack` and `tick` in the same cycle in ALARM: exit to IDLE, no counter update.
- `clear` together with `load_valid` in IDLE: the load is not accepted.

## Structure
- Package `timer_pkg` holds:
  - `state_t` enum (IDLE, RUN, PAUSE, ALARM), 2-bit;
  - default `WIDTH` and `ALARM_TICKS` localparams, shared with the display logic.
- Single flat module. No sub-module is needed; the tick source is instantiated alongside at top level, not inside.
- One always_ff for state, `remaining`, alarm counter and output registers; one always_comb for next-state.

## Test plan
- Reset then load 3 → `busy`=1, `remaining`=3. After 3 ticks: `remaining`=0, `done` high exactly one cycle, `alarm`=1. After 5 more ticks: IDLE, `alarm`=0, `load_ready`=1.
- Load 10, 4 ticks, `pause`=1 for 3 ticks, release, 6 more ticks → `remaining` holds 6 during the pause; expiry on the 6th post-pause tick.
- Load 0 → ALARM on the next edge with a `done` pulse. `ack` on 2nd tick → IDLE; alarm lasted 1 tick.
- Load 200, 50 ticks, `clear` → all outputs at reset values next cycle. `load_valid` asserted during RUN is never accepted.
- `pause` and `tick` in the same cycle with `remaining`=1 → PAUSE, `remaining` stays 1, no `done`.
- `nrst`=0 for one cycle while in ALARM → reset values on the following cycle. Load 2 afterward → normal expiry after 2 ticks.
